// File: rtl/fetch_enq.sv
// Fetch front end: issues sequential instruction reads, tags returning words with their PC,
// and pushes {pc, inst} into the instruction queue through a 2-entry skid buffer.
`timescale 1ns/1ps
module fetch_enq #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [XLEN-1:0]   flush_pc,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_resp,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              q_space_avail,
    output logic              enq_en,
    output logic [2*XLEN-1:0] enq_data
);

    logic [XLEN-1:0]   pc;
    logic [1:0]        oc;
    logic [1:0]        dc;
    logic [1:0]        hc;
    logic [XLEN-1:0]   tag_mem [2];
    logic              tag_rd;
    logic              tag_wr;
    logic [2*XLEN-1:0] skid_mem [2];
    logic              skid_rd;

    logic              credit_ok;
    logic              issue;
    logic              resp_pop;
    logic              resp_live;
    logic              drain;
    logic              bypass;
    logic              skid_push;
    logic              skid_wr;
    logic [2*XLEN-1:0] resp_word;
    logic [1:0]        oc_next;

    // Credit uses the pre-update counts, so a same-cycle response never frees a slot early.
    always_comb begin
        credit_ok = ({1'b0, oc} + {1'b0, hc}) < 3'(DEPTH);
        issue     = rst & ~flush & credit_ok;
        resp_pop  = imem_resp & (oc != 2'd0);
        resp_live = resp_pop & ~flush & (dc == 2'd0);
        resp_word = {tag_mem[tag_rd], imem_rdata};
        drain     = rst & ~flush & q_space_avail & (hc != 2'd0);
        bypass    = rst & ~flush & q_space_avail & (hc == 2'd0) & resp_live;
        skid_push = resp_live & ~bypass;
        skid_wr   = skid_rd ^ hc[0];
        oc_next   = oc + {1'b0, issue} - {1'b0, resp_pop};

        imem_req  = issue;
        imem_addr = pc;
        enq_en    = drain | bypass;
        enq_data  = '0;
        if (drain) begin
            enq_data = skid_mem[skid_rd];
        end else if (bypass) begin
            enq_data = resp_word;
        end
    end

    // Doomed requests keep their tag entries and credit until they return, then pop silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            oc          <= '0;
            dc          <= '0;
            hc          <= '0;
            tag_rd      <= 1'b0;
            tag_wr      <= 1'b0;
            skid_rd     <= 1'b0;
            tag_mem[0]  <= '0;
            tag_mem[1]  <= '0;
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
        end else begin
            if (flush) begin
                pc <= flush_pc;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            if (issue) begin
                tag_mem[tag_wr] <= pc;
                tag_wr          <= ~tag_wr;
            end
            if (resp_pop) begin
                tag_rd <= ~tag_rd;
            end
            oc <= oc_next;

            if (flush) begin
                dc <= oc - {1'b0, resp_pop};
            end else if (resp_pop && dc != 2'd0) begin
                dc <= dc - 2'd1;
            end

            if (flush) begin
                hc      <= '0;
                skid_rd <= 1'b0;
            end else begin
                hc <= hc + {1'b0, skid_push} - {1'b0, drain};
                if (drain) begin
                    skid_rd <= ~skid_rd;
                end
                if (skid_push) begin
                    skid_mem[skid_wr] <= resp_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_enq.sv
// Scoreboard bench for fetch_enq: a behavioural instruction memory answers requests, directed
// scenarios push the expected {pc, inst} stream, and a negedge monitor checks every enqueue.
`timescale 1ns/1ps
module tb_fetch_enq;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        q_space_avail;
    logic        enq_en;
    logic [63:0] enq_data;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [63:0] exp_q[$];
    int          mem_lat;
    int          cyc;
    int          total;
    int          bad;
    logic        mon_en;

    fetch_enq dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .q_space_avail (q_space_avail),
        .enq_en        (enq_en),
        .enq_data      (enq_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579bdf;
    endfunction

    // Memory model: answers in request order exactly mem_lat cycles after issue; forgets all on reset.
    initial begin
        imem_resp  = 1'b0;
        imem_rdata = '0;
        cyc        = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                imem_resp  = 1'b1;
                imem_rdata = inst_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_resp  = 1'b0;
                imem_rdata = 32'hdeadbeef;
            end
            #2;
            if (!rst) begin
                mem_q.delete();
            end else if (imem_req) begin
                mem_q.push_back('{addr: imem_addr, due: cyc + mem_lat});
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && enq_en) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("[TB] FAIL unexpected_enq: got %h expected no push", enq_data);
            end else begin
                logic [63:0] want;
                want = exp_q.pop_front();
                if (enq_data !== want) begin
                    bad = bad + 1;
                    $display("[TB] FAIL enq_data: got %h expected %h", enq_data, want);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic f, input logic [31:0] fpc, input logic qs);
        flush         = f;
        flush_pc      = fpc;
        q_space_avail = qs;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            exp_q.push_back({a, inst_of(a)});
        end
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1);
        mon_en  = 1'b0;
        mem_lat = lat;
        tick();
        tick();
        exp_q.delete();
        check_output("reset_req", {63'd0, imem_req}, 64'd0);
        check_output("reset_enq_en", {63'd0, enq_en}, 64'd0);
        check_output("reset_enq_data", enq_data, 64'd0);
        check_output("reset_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
    endtask

    task automatic release_reset();
        rst = 1'b1;
        #2;
        check_output("first_req", {63'd0, imem_req}, 64'd1);
        check_output("first_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max && exp_q.size() > 0; i++) begin
            tick();
        end
        check_output(name, 64'(exp_q.size()), 64'd0);
        q_space_avail = 1'b0;
        mon_en        = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        mon_en = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1);
        mem_lat = 1;

        $display("[TB] streaming with 1-cycle memory");
        do_reset(1);
        push_seq(RESET_PC, 8);
        mon_en = 1'b1;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            check_output("stream_enq_en", {63'd0, enq_en}, 64'd1);
        end
        wait_drain("stream_drain", 40);

        $display("[TB] queue full for 5 cycles");
        do_reset(1);
        push_seq(RESET_PC, 12);
        mon_en = 1'b1;
        release_reset();
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            q_space_avail = 1'b0;
            if (i >= 2) begin
                #2;
                check_output("stall_req", {63'd0, imem_req}, 64'd0);
                check_output("stall_enq_en", {63'd0, enq_en}, 64'd0);
            end
        end
        tick();
        q_space_avail = 1'b1;
        #2;
        check_output("stall_release_data", enq_data, {RESET_PC + 32'hc, inst_of(RESET_PC + 32'hc)});
        wait_drain("stall_drain", 40);

        $display("[TB] flush with two outstanding, 2-cycle memory");
        do_reset(2);
        push_seq(32'h1000, 4);
        mon_en = 1'b1;
        release_reset();
        tick();
        tick();
        apply_stimulus(1'b1, 32'h1000, 1'b1);
        #2;
        check_output("flush_oc2_req", {63'd0, imem_req}, 64'd0);
        check_output("flush_oc2_enq_en", {63'd0, enq_en}, 64'd0);
        tick();
        flush = 1'b0;
        #2;
        check_output("post_flush_req", {63'd0, imem_req}, 64'd1);
        check_output("post_flush_addr", {32'd0, imem_addr}, 64'h1000);
        check_output("drop_enq_en", {63'd0, enq_en}, 64'd0);
        wait_drain("flush_oc2_drain", 40);

        $display("[TB] flush with full skid buffer");
        do_reset(1);
        release_reset();
        tick();
        tick();
        tick();
        q_space_avail = 1'b0;
        tick();
        tick();
        tick();
        apply_stimulus(1'b1, 32'h2000, 1'b1);
        mon_en = 1'b1;
        push_seq(32'h2000, 3);
        #2;
        check_output("flush_hc2_enq_en", {63'd0, enq_en}, 64'd0);
        tick();
        flush = 1'b0;
        #2;
        check_output("flush_hc2_addr", {32'd0, imem_addr}, 64'h2000);
        wait_drain("flush_hc2_drain", 40);

        $display("[TB] back-to-back flush, first with a response");
        do_reset(1);
        release_reset();
        repeat (3) tick();
        tick();
        apply_stimulus(1'b1, 32'h3000, 1'b1);
        mon_en = 1'b1;
        push_seq(32'h4000, 3);
        #2;
        check_output("flush_resp_enq_en", {63'd0, enq_en}, 64'd0);
        tick();
        flush_pc = 32'h4000;
        #2;
        check_output("flush2_req", {63'd0, imem_req}, 64'd0);
        tick();
        flush = 1'b0;
        #2;
        check_output("flush2_addr", {32'd0, imem_addr}, 64'h4000);
        wait_drain("flush2_drain", 40);

        $display("[TB] pc wrap");
        do_reset(1);
        push_seq(32'hfffffffc, 3);
        release_reset();
        tick();
        apply_stimulus(1'b1, 32'hfffffffc, 1'b1);
        mon_en = 1'b1;
        tick();
        flush = 1'b0;
        #2;
        check_output("wrap_top_addr", {32'd0, imem_addr}, 64'hfffffffc);
        tick();
        #2;
        check_output("wrap_addr", {32'd0, imem_addr}, 64'h0);
        check_output("wrap_req", {63'd0, imem_req}, 64'd1);
        wait_drain("wrap_drain", 40);

        $display("[TB] asynchronous reset mid-stream");
        do_reset(1);
        push_seq(RESET_PC, 3);
        mon_en = 1'b1;
        release_reset();
        repeat (3) tick();
        tick();
        mon_en = 1'b0;
        #2;
        check_output("pre_reset_req", {63'd0, imem_req}, 64'd1);
        check_output("pre_reset_enq_en", {63'd0, enq_en}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("async_req", {63'd0, imem_req}, 64'd0);
        check_output("async_enq_en", {63'd0, enq_en}, 64'd0);
        check_output("async_enq_data", enq_data, 64'd0);
        check_output("scoreboard_before_restart", 64'(exp_q.size()), 64'd0);
        do_reset(1);
        push_seq(RESET_PC, 4);
        mon_en = 1'b1;
        release_reset();
        wait_drain("restart_drain", 40);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
